// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one XNOR LFSR among NREQ requesters.
// Optional LFSR_RR_SCHED_BACKPRESSURE_EN adds rnd_ready flow control.
module lfsr_rr_sched #(
    parameter int WIDTH = 5,
    parameter int TAP_A = 1,
    parameter int TAP_B = 3,
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seed_load,
    input  logic [WIDTH-1:0]          seed,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*LEN_W-1:0]     req_len,
`ifdef LFSR_RR_SCHED_BACKPRESSURE_EN
    input  logic                      rnd_ready,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic                      rnd_valid,
    output logic [WIDTH-1:0]          rnd_data,
    output logic [$clog2(NREQ)-1:0]   rnd_id,
    output logic                      rnd_last,
    output logic                      busy,
    output logic                      lockup
);

    localparam int ID_W = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_s;
    logic [ID_W-1:0]    r_ptr;
    logic [LEN_W-1:0]   r_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [ID_W-1:0]    r_id;
    logic               r_last;
    logic               r_lockup;

    state_t             w_state_n;
    logic [WIDTH-1:0]   w_s_n;
    logic [ID_W-1:0]    w_ptr_n;
    logic [LEN_W-1:0]   w_cnt_n;
    logic [NREQ-1:0]    w_gnt_n;
    logic               w_valid_n;
    logic [WIDTH-1:0]   w_data_n;
    logic [ID_W-1:0]    w_id_n;
    logic               w_last_n;
    logic               w_lock_n;

    logic               w_ones;
    logic               w_fb;
    logic [WIDTH-1:0]   w_step;
    logic               w_take;
    logic               w_hit;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_cand;
    logic [LEN_W-1:0]   w_len [NREQ];

    // All-ones is the XNOR dead state; escape through zero.
    assign w_ones = &r_s;
    assign w_fb   = ~(r_s[TAP_A] ^ r_s[TAP_B]);
    assign w_step = w_ones ? '0 : {r_s[WIDTH-2:0], w_fb};

`ifdef LFSR_RR_SCHED_BACKPRESSURE_EN
    assign w_take = ~r_valid | rnd_ready;
`else
    assign w_take = 1'b1;
`endif

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign w_len[g] = req_len[g*LEN_W +: LEN_W];
    end

    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % NREQ);
            if (!w_hit && req[w_cand]) begin
                w_hit = 1'b1;
                w_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_s_n     = r_s;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        w_gnt_n   = r_gnt;
        w_valid_n = r_valid;
        w_data_n  = r_data;
        w_id_n    = r_id;
        w_last_n  = r_last;
        w_lock_n  = r_lockup;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_valid_n = 1'b0;
                    w_last_n  = 1'b0;
                end
                // A pending unaccepted last word blocks the next grant.
                if (seed_load) begin
                    w_s_n    = seed;
                    w_lock_n = 1'b0;
                end else if (w_hit && w_take) begin
                    w_ptr_n   = w_idx;
                    w_cnt_n   = w_len[w_idx];
                    w_gnt_n   = NREQ'(1) << w_idx;
                    w_id_n    = w_idx;
                    w_state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_take) begin
                    w_s_n     = w_step;
                    w_lock_n  = r_lockup | w_ones;
                    w_valid_n = 1'b1;
                    w_data_n  = w_step;
                    w_last_n  = (r_cnt == '0);
                    w_cnt_n   = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_state_n = ST_IDLE;
                        w_gnt_n   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_s      <= '0;
            r_ptr    <= ID_W'(NREQ - 1);
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_id     <= '0;
            r_last   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_s      <= w_s_n;
            r_ptr    <= w_ptr_n;
            r_cnt    <= w_cnt_n;
            r_gnt    <= w_gnt_n;
            r_valid  <= w_valid_n;
            r_data   <= w_data_n;
            r_id     <= w_id_n;
            r_last   <= w_last_n;
            r_lockup <= w_lock_n;
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;
    assign rnd_id    = r_id;
    assign rnd_last  = r_last;
    assign busy      = (r_state == ST_RUN);
    assign lockup    = r_lockup;

endmodule

// File: doc/lfsr_rr_sched.md
Name: lfsr_rr_sched

Overview:
- Round-robin scheduler that shares one internal XNOR-feedback LFSR among NREQ requesters.
- Each granted requester receives a burst of pseudo-random words tagged with its ID.
- Provides seed loading and XNOR lock-up detection and recovery.
- Sits between the test-pattern consumers (BIST, scramblers) and the LFSR datapath, so no consumer owns the generator directly.

Parameters:
- WIDTH, 5: LFSR and output word width (minimum 4).
- TAP_A, 1: first feedback tap bit index.
- TAP_B, 3: second feedback tap bit index.
- NREQ, 4: number of requesters (minimum 2).
- LEN_W, 4: burst-length field width per requester.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- seed_load  in  1  load seed into LFSR; honoured only in IDLE.
- seed  in  WIDTH  seed value.
- req  in  NREQ  per-requester request level.
- req_len  in  NREQ*LEN_W  per-requester burst length; slice i is [i*LEN_W +: LEN_W]; value L means L+1 words.
- gnt  out  NREQ  one-hot grant, registered.
- rnd_valid  out  1  rnd_data valid this cycle.
- rnd_data  out  WIDTH  random word.
- rnd_id  out  clog2(NREQ)  requester index owning the word.
- rnd_last  out  1  final word of the burst.
- busy  out  1  high when state is RUN.
- lockup  out  1  sticky lock-up flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - LFSR state s=0, state=IDLE.
  - gnt, rnd_valid, rnd_data, rnd_id, rnd_last, busy, lockup all 0.
  - RR pointer = NREQ-1, so req[0] has first priority.
- Step function: s_next = {s[WIDTH-2:0], ~(s[TAP_A]^s[TAP_B])}. If s is all-ones (the XNOR lock-up state), s_next=0 instead and lockup<=1.
- IDLE state:
  - seed_load=1 takes priority: s<=seed, lockup<=0, stay IDLE. Any req waits until the next cycle.
  - Otherwise, if req!=0, pick the first set bit searching from ptr+1 upward with wrap. Then, at that edge: ptr<=idx, cnt<=req_len[idx], gnt<=onehot(idx), rnd_id<=idx, state<=RUN.
  - Otherwise stay IDLE; s holds.
- RUN state, each edge:
  - s<=s_next.
  - rnd_valid<=1, rnd_data<=s_next, rnd_last<=(cnt==0).
  - cnt<=cnt-1.
  - If cnt==0: state<=IDLE and gnt<=0.
- Output rules:
  - rnd_valid is low in any cycle not preceded by a RUN edge.
  - busy = (state==RUN).
- Latency:
  - req seen in cycle T → gnt high in T+1.
  - First rnd_valid in T+2.
  - Last word in T+L+2.
  - gnt is high for exactly L+1 cycles.
- Back-to-back bursts: one bubble cycle (the IDLE arbitration cycle) between bursts. The last rnd_valid cycle overlaps that IDLE cycle.
- Mid-burst events:
  - req deassertion, changes to other req bits, and req_len changes are ignored; the burst always completes.
  - seed_load during RUN is ignored (not queued).
- Fairness: a continuously requesting requester is served at most once per NREQ grants when all requesters request.
- Reset mid-burst: immediate return to reset values; the partial burst is discarded.

Optional Feature:
- Macro: LFSR_RR_SCHED_BACKPRESSURE_EN.
- With the macro defined:
  - Adds input port rnd_ready (1 bit).
  - In RUN, when rnd_valid=1 and rnd_ready=0, the RUN edge is stalled: s, cnt, state, gnt and all rnd_* outputs hold.
  - A word is consumed only when rnd_valid & rnd_ready.
  - rnd_last falls after its word is accepted.
- Without the macro: no rnd_ready port; every valid word is consumed in its cycle, as above.

Test Plan:
- Reset, then req=0001, req_len[0]=4 → gnt=0001 for 5 cycles; rnd_data 0x01,0x03,0x06,0x0C,0x18, rnd_id=0, rnd_last only on 0x18; busy falls after.
- req=1111, all len=0 held high → grants in order 0001,0010,0100,1000,0001, each 1 cycle with a 1-cycle bubble between grants.
- seed_load=1, seed=0x1F in IDLE, then req=0010, len=1 → words 0x00, 0x01; lockup=1 from the first word and stays 1 until the next seed_load clears it.
- seed_load and req=0100 in the same IDLE cycle → seed is loaded first, gnt=0100 one cycle later; seed_load pulsed during RUN → s unaffected.
- rst driven low in the middle of a 16-word burst → all outputs 0 asynchronously; after release, req=0001 len 0 yields 0x01.
- With LFSR_RR_SCHED_BACKPRESSURE_EN, len=2, rnd_ready held low 3 cycles on the 2nd word → the word holds stable; the burst delivers 0x01, 0x03, 0x06 with no loss.
